// File: rtl/multibyte_add_sequencer.sv
// Byte-serial adder/subtractor: one 8-bit adder walks the operands LS byte first,
// producing a full-width sum/difference, carry-out and signed overflow.
module multibyte_add_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic                  sub,
    input  logic                  cin,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic                  overflow
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            res_valid_q, res_valid_d;

    logic [7:0]      byte_a, byte_b;
    logic [8:0]      sum9;
    logic            msb_cin;

    always_comb begin
        byte_a  = a_q[{idx_q, 3'b000} +: 8];
        byte_b  = b_q[{idx_q, 3'b000} +: 8];
        sum9    = {1'b0, byte_a} + {1'b0, byte_b} + {8'b0, carry_q};
        // carry into bit 7 recovered from the sum bit and the two operand bits
        msb_cin = sum9[7] ^ byte_a[7] ^ byte_b[7];

        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        res_valid_d = res_valid_q;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[{idx_q, 3'b000} +: 8] = sum9[7:0];
                carry_d = sum9[8];
                cout_d  = sum9[8];
                ovf_d   = msb_cin ^ sum9[8];
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    res_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = res_valid_q;
    assign result      = result_q;
    assign cout        = cout_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Scoreboard bench for multibyte_add_sequencer: accepted requests push a
// full-width arithmetic prediction, a monitor pops it when the result is offered.
module tb_multibyte_add_sequencer;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [W-1:0]  op_a, op_b;
    logic          sub, cin;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  result;
    logic          cout, overflow;

    multibyte_add_sequencer #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub), .cin(cin),
        .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        int unsigned  ecyc;
    } exp_t;

    exp_t        q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    logic          use_tab = 1'b0;
    logic [W-1:0]  tab_r;
    logic          tab_c, tab_v;
    logic          b2b = 1'b0;
    int unsigned   b2b_acc = 0;
    int unsigned   last_acc = 0;
    logic          have_last = 1'b0;
    logic          prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Signed overflow: operands of equal sign producing a result of the other sign.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic ci);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : ci)};
        e.r  = full[W-1:0];
        e.c  = full[W];
        e.v  = (a[W-1] == bb[W-1]) && (e.r[W-1] != a[W-1]);
        e.ecyc = 0;
        return e;
    endfunction

    // Request side of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            have_last = 1'b0;
        end else if (start_valid && start_ready) begin
            if (use_tab) begin
                e.r = tab_r; e.c = tab_c; e.v = tab_v;
            end else begin
                e = model(op_a, op_b, sub, cin);
            end
            e.ecyc = cyc + 1 + NB;
            q.push_back(e);
            if (b2b) begin
                if (have_last) chk("b2b_spacing", 64'(cyc - last_acc), 64'(NB + 2));
                b2b_acc++;
            end
            last_acc  = cyc;
            have_last = b2b;
        end
    end

    // Response side of the scoreboard.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            chk("ready_low_in_done", 64'(start_ready), 64'(0));
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_res_valid actual=1 required=0 (t=%0t)", $time);
            end else begin
                if (!prev_v) chk("latency", 64'(cyc), 64'(q[0].ecyc));
                chk("result", 64'(result), 64'(q[0].r));
                chk("cout", 64'(cout), 64'(q[0].c));
                chk("overflow", 64'(overflow), 64'(q[0].v));
                if (res_ready) void'(q.pop_front());
            end
        end
        prev_v = res_valid;
    end

    task automatic scramble();
        op_a = $urandom; op_b = $urandom;
        sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic ci);
        logic acc;
        op_a = a; op_b = b; sub = s; cin = ci;
        start_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = start_ready;
            @(posedge clk); #1;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        start_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_done(input logic rnd);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (q.size() == 0 && start_ready && !res_valid) ok = 1'b1;
            else begin
                res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                @(posedge clk); #1;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=busy required=idle");
        end
        res_ready = 1'b1;
    endtask

    logic [W-1:0] ta [7] = '{32'hFFFFFFFF, 32'h00000005, 32'h80000000, 32'h7FFFFFFF,
                             32'h12345678, 32'h0000000A, 32'hFFFFFFFF};
    logic [W-1:0] tb_ [7] = '{32'h00000001, 32'h00000007, 32'h00000001, 32'h00000001,
                              32'h11111111, 32'h00000003, 32'hFFFFFFFF};
    logic         ts [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         tc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] tr [7] = '{32'h00000000, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h80000000,
                             32'h2345678A, 32'h00000007, 32'hFFFFFFFF};
    logic         tco [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic         tv [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        rst = 1'b1; start_valid = 1'b0; res_ready = 1'b1;
        op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", 64'(start_ready), 64'(1));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        rst = 1'b0;

        use_tab = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tab_r = tr[i]; tab_c = tco[i]; tab_v = tv[i];
            issue(ta[i], tb_[i], ts[i], tc[i]);
            wait_done(1'b0);
        end
        use_tab = 1'b0;

        // Stall in DONE while new requests are offered; they must be ignored.
        res_ready = 1'b0;
        issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        start_valid = 1'b1;
        for (int i = 0; i < NB + 5; i++) begin
            chk("busy_ready_low", 64'(start_ready), 64'(0));
            @(posedge clk); #1;
            scramble();
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_gap_ready", 64'(start_ready), 64'(1));
        chk("idle_gap_valid", 64'(res_valid), 64'(0));
        @(posedge clk); #1;
        start_valid = 1'b0;
        chk("accept_after_gap", 64'(start_ready), 64'(0));
        wait_done(1'b0);

        // Abort in the middle of RUN.
        issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        @(posedge clk); #1;
        rst = 1'b1; start_valid = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start_valid = 1'b0;
        chk("abort_ready", 64'(start_ready), 64'(1));
        chk("abort_valid", 64'(res_valid), 64'(0));
        chk("abort_result", 64'(result), 64'(0));
        repeat (NB + 2) @(posedge clk);
        #1;
        issue(32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0);
        wait_done(1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            a = $urandom; b = $urandom;
            if (i % 8 == 0) a = '1;
            if (i % 8 == 1) b = 32'h80000000;
            issue(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_done(1'b1);
        end

        b2b = 1'b1; res_ready = 1'b1; start_valid = 1'b1;
        for (int i = 0; i < 6 * (NB + 2) + 2; i++) begin
            @(posedge clk); #1;
            scramble();
        end
        start_valid = 1'b0;
        wait_done(1'b0);
        b2b = 1'b0;
        chk("b2b_accepts_ge6", 64'(b2b_acc >= 6), 64'(1));
        chk("queue_drained", 64'(q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/multibyte_add_sequencer.md
MULTIBYTE_ADD_SEQUENCER -- requirements
Module: multibyte_add_sequencer

Interface
REQ-001 SHALL have parameter NBYTES, default 4, meaning operand width in bytes; legal range 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_valid  input  1  request present.
REQ-005 SHALL have port start_ready  output  1  block can accept a request.
REQ-006 SHALL have port op_a  input  8*NBYTES  first operand (augend/minuend).
REQ-007 SHALL have port op_b  input  8*NBYTES  second operand (addend/subtrahend).
REQ-008 SHALL have port sub  input  1  0 = add, 1 = subtract (A - B).
REQ-009 SHALL have port cin  input  1  carry-in for add; ignored when sub=1.
REQ-010 SHALL have port res_valid  output  1  result available.
REQ-011 SHALL have port res_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  8*NBYTES  sum/difference.
REQ-013 SHALL have port cout  output  1  final carry out of MS byte (for sub: 1 = no borrow).
REQ-014 SHALL have port overflow  output  1  signed two's-complement overflow.

Function
REQ-015 SHALL contain exactly one 8-bit add datapath (8-bit A, 8-bit B, carry-in; 8-bit sum, carry-out) reused every byte step; no full-width adder.
REQ-016 SHALL implement states IDLE, RUN, DONE.
REQ-017 IDLE: start_ready=1, res_valid=0; on start_valid=1 at an edge, SHALL latch op_a, op_b (inverted if sub=1), initial carry (1 if sub=1, else cin), byte index 0, go RUN.
REQ-018 RUN: each edge SHALL add latched byte[index] of A and B with carry register, write sum into result byte[index], update carry register with byte carry-out, increment index.
REQ-019 RUN SHALL last exactly NBYTES cycles, bytes processed LS first; on the edge processing byte NBYTES-1 SHALL go DONE.
REQ-020 Latency: request accepted at edge k -> res_valid=1 after edge k+NBYTES.
REQ-021 DONE: res_valid=1; result, cout, overflow stable; start_ready=0.
REQ-022 DONE with res_ready=1 at an edge SHALL return to IDLE; result/cout/overflow hold last values in IDLE.
REQ-023 start_ready SHALL be 0 in RUN and DONE; start_valid there SHALL be ignored (no queueing, no latch update).
REQ-024 A DONE->IDLE edge SHALL NOT accept a new request in the same cycle; earliest next accept is the following edge (start_ready is combinational on state only).
REQ-025 overflow SHALL equal carry into MS bit XOR carry out of MS bit of the final byte step.
REQ-026 Operand/sub/cin changes after acceptance SHALL have no effect on the operation in progress.
REQ-027 Arithmetic modulo 2^(8*NBYTES); all-ones + 1 wraps to 0 with cout=1.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, index 0, carry 0, result 0, cout 0, overflow 0, res_valid 0, start_ready 1, in any state.
REQ-029 rst asserted during RUN or DONE SHALL abort the operation with no res_valid pulse; rst dominates start_valid and res_ready in the same cycle.

Verification (NBYTES=4)
REQ-030 Add 0xFFFFFFFF + 0x00000001, cin=0, res_ready=1 -> res_valid 4 cycles after accept, result 0x00000000, cout=1, overflow=0.
REQ-031 Sub 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, cout=0, overflow=0; sub 0x80000000 - 1 -> 0x7FFFFFFF, overflow=1.
REQ-032 Add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, cout=0; add 0x12345678 + 0x11111111, cin=1 -> 0x2345678A.
REQ-033 Hold res_ready=0 for 3 cycles in DONE -> res_valid, result stable; start_valid=1 with new operands during RUN/DONE ignored; after release, IDLE for one cycle, then new request accepted.
REQ-034 Assert rst for one cycle at RUN cycle 2 -> next cycle IDLE, result 0, res_valid never asserted for that request; subsequent request completes correctly.
REQ-035 Back-to-back requests with start_valid and res_ready held 1 -> one accept every NBYTES+2 cycles, each result correct.
